// File: rtl/endp_flit_injector.sv
// Endpoint packet-to-flit injector: turns packet requests plus a payload stream
// into header/body/tail flits for one router local input, with per-VC credit flow control.
module endp_flit_injector #(
  parameter int V            = 2,
  parameter int B            = 4,
  parameter int Fw           = 32,
  parameter int EAw          = 8,
  parameter int MAX_PCK_SIZE = 16,
  parameter int LENw         = 5,
  parameter int SRC_ADDR     = 0,
  localparam int VW          = (V > 1) ? $clog2(V) : 1,
  localparam int CW          = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [EAw-1:0]  req_dest,
  input  logic [LENw-1:0] req_len,
  input  logic [VW-1:0]   req_vc,
  input  logic            pl_valid,
  output logic            pl_ready,
  input  logic [Fw-1:0]   pl_data,
  output logic            flit_out_wr,
  output logic            flit_out_hdr,
  output logic            flit_out_tail,
  output logic [V-1:0]    flit_out_vc,
  output logic [Fw-1:0]   flit_out_data,
  input  logic [V-1:0]    credit_in,
  output logic            credit_err,
  output logic [31:0]     sent_pck_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t          state_reg;
  logic [EAw-1:0]  dest_reg;
  logic [VW-1:0]   vc_reg;
  logic [LENw-1:0] len_reg;
  logic [LENw-1:0] rem_reg;

  logic [CW-1:0]   credit_reg [V];
  logic [V-1:0]    credit_avail;
  logic [V-1:0]    issue_vc;
  logic [V-1:0]    credit_ovf;

  logic            cur_credit_ok;
  logic            issue_hdr;
  logic            issue_body;
  logic            issue;
  logic            is_tail;
  logic            accept;
  logic [LENw-1:0] len_clamped;
  logic            len_illegal;
  logic [Fw-1:0]   hdr_data;

  assign cur_credit_ok = credit_avail[vc_reg];
  assign issue_hdr     = (state_reg == HDR) && cur_credit_ok;
  assign issue_body    = (state_reg == BODY) && pl_valid && cur_credit_ok;
  assign issue         = issue_hdr || issue_body;
  assign is_tail       = issue_hdr ? (len_reg == LENw'(1)) : (rem_reg == LENw'(1));

  assign req_ready = !reset && (state_reg == IDLE);
  assign pl_ready  = !reset && issue_body;
  assign accept    = req_valid && req_ready;

  always_comb begin
    len_clamped = req_len;
    len_illegal = 1'b0;
    if (req_len == '0) begin
      len_clamped = LENw'(1);
    end else if (req_len > LENw'(MAX_PCK_SIZE)) begin
      len_clamped = LENw'(MAX_PCK_SIZE);
      len_illegal = 1'b1;
    end
  end

  always_comb begin
    hdr_data                        = '0;
    hdr_data[EAw-1:0]               = dest_reg;
    hdr_data[2*EAw-1:EAw]           = EAw'(SRC_ADDR);
    hdr_data[2*EAw+LENw-1:2*EAw]    = len_reg;
  end

  // One credit counter per VC; tracked every cycle regardless of FSM state.
  generate
    for (genvar gi = 0; gi < V; gi++) begin : g_credit
      assign issue_vc[gi]     = issue && (vc_reg == VW'(gi));
      assign credit_avail[gi] = (credit_reg[gi] != '0);
      assign credit_ovf[gi]   = credit_in[gi] && !issue_vc[gi] && (credit_reg[gi] == CW'(B));

      always_ff @(posedge clk) begin
        if (reset) begin
          credit_reg[gi] <= CW'(B);
        end else begin
          case ({credit_in[gi], issue_vc[gi]})
            2'b10:   if (credit_reg[gi] != CW'(B)) credit_reg[gi] <= credit_reg[gi] + CW'(1);
            2'b01:   credit_reg[gi] <= credit_reg[gi] - CW'(1);
            default: credit_reg[gi] <= credit_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      dest_reg      <= '0;
      vc_reg        <= '0;
      len_reg       <= '0;
      rem_reg       <= '0;
      flit_out_wr   <= 1'b0;
      flit_out_hdr  <= 1'b0;
      flit_out_tail <= 1'b0;
      flit_out_vc   <= '0;
      flit_out_data <= '0;
      credit_err    <= 1'b0;
      sent_pck_cnt  <= '0;
    end else begin
      credit_err    <= credit_err || (|credit_ovf) || (accept && len_illegal);
      flit_out_wr   <= issue;
      flit_out_hdr  <= issue_hdr;
      flit_out_tail <= issue && is_tail;
      flit_out_vc   <= issue ? (V'(1) << vc_reg) : '0;
      flit_out_data <= issue_hdr ? hdr_data : (issue_body ? pl_data : '0);

      if (issue && is_tail) begin
        sent_pck_cnt <= sent_pck_cnt + 32'd1;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            dest_reg  <= req_dest;
            vc_reg    <= req_vc;
            len_reg   <= len_clamped;
            state_reg <= HDR;
          end
        end
        HDR: begin
          if (issue_hdr) begin
            rem_reg   <= len_reg - LENw'(1);
            state_reg <= is_tail ? IDLE : BODY;
          end
        end
        BODY: begin
          if (issue_body) begin
            rem_reg <= rem_reg - LENw'(1);
            if (is_tail) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_endp_flit_injector.sv
// Directed bench for endp_flit_injector: hand-computed flit sequences, credit
// stalls, overflow/clamp error flag and mid-packet reset.
module tb_endp_flit_injector;

  localparam int V    = 2;
  localparam int B    = 4;
  localparam int Fw   = 32;
  localparam int EAw  = 8;
  localparam int LENw = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [EAw-1:0]  req_dest;
  logic [LENw-1:0] req_len;
  logic [0:0]      req_vc;
  logic            pl_valid;
  logic            pl_ready;
  logic [Fw-1:0]   pl_data;
  logic            flit_out_wr;
  logic            flit_out_hdr;
  logic            flit_out_tail;
  logic [V-1:0]    flit_out_vc;
  logic [Fw-1:0]   flit_out_data;
  logic [V-1:0]    credit_in;
  logic            credit_err;
  logic [31:0]     sent_pck_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  endp_flit_injector #(
    .V(V), .B(B), .Fw(Fw), .EAw(EAw), .MAX_PCK_SIZE(16), .LENw(LENw), .SRC_ADDR(0)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_len(req_len), .req_vc(req_vc),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .flit_out_wr(flit_out_wr), .flit_out_hdr(flit_out_hdr), .flit_out_tail(flit_out_tail),
    .flit_out_vc(flit_out_vc), .flit_out_data(flit_out_data),
    .credit_in(credit_in), .credit_err(credit_err), .sent_pck_cnt(sent_pck_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic hdr, input logic tail,
                             input logic [V-1:0] vc, input logic [Fw-1:0] data);
    $display("[TB] %s: wr=%b hdr=%b tail=%b vc=%b data=%h",
             tag, flit_out_wr, flit_out_hdr, flit_out_tail, flit_out_vc, flit_out_data);
    check({tag, ".wr"},   64'(flit_out_wr),   64'(1'b1));
    check({tag, ".hdr"},  64'(flit_out_hdr),  64'(hdr));
    check({tag, ".tail"}, 64'(flit_out_tail), 64'(tail));
    check({tag, ".vc"},   64'(flit_out_vc),   64'(vc));
    check({tag, ".data"}, 64'(flit_out_data), 64'(data));
  endtask

  task automatic expect_no_flit(input string tag);
    $display("[TB] %s: wr=%b vc=%b", tag, flit_out_wr, flit_out_vc);
    check({tag, ".wr"}, 64'(flit_out_wr), 64'(1'b0));
    check({tag, ".vc"}, 64'(flit_out_vc), 64'(2'b00));
  endtask

  task automatic request(input logic [EAw-1:0] dest, input logic [LENw-1:0] len, input logic vc);
    req_valid = 1'b1;
    req_dest  = dest;
    req_len   = len;
    req_vc    = vc;
    #1;
    check("req_ready_idle", 64'(req_ready), 64'(1'b1));
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_dest  = '0;
    req_len   = '0;
    req_vc    = '0;
    pl_valid  = 1'b1;
    pl_data   = '0;
    credit_in = '0;

    // Reset state
    tick();
    tick();
    check("rst.req_ready", 64'(req_ready), 64'(1'b0));
    check("rst.pl_ready",  64'(pl_ready),  64'(1'b0));
    check("rst.wr",        64'(flit_out_wr), 64'(1'b0));
    check("rst.err",       64'(credit_err), 64'(1'b0));
    check("rst.cnt",       64'(sent_pck_cnt), 64'(0));
    reset    = 1'b0;
    pl_valid = 1'b0;
    #1;
    check("post_rst.req_ready", 64'(req_ready), 64'(1'b1));

    // Single-flit packet: dest=5, len=1, vc=0
    request(8'd5, 5'd1, 1'b0);
    expect_no_flit("t1.idle_cycle");
    check("t1.req_ready_hdr", 64'(req_ready), 64'(1'b0));
    tick();
    expect_flit("t1.hdr", 1'b1, 1'b1, 2'b01, 32'h0001_0005);
    check("t1.cnt", 64'(sent_pck_cnt), 64'(1));
    tick();
    expect_no_flit("t1.after");

    // len=4 on vc1, payload A,B,C always valid
    pl_valid = 1'b1;
    pl_data  = 32'hA;
    #1;
    check("t2.pl_ready_idle", 64'(pl_ready), 64'(1'b0));
    request(8'd7, 5'd4, 1'b1);
    tick();
    expect_flit("t2.hdr", 1'b1, 1'b0, 2'b10, 32'h0004_0007);
    check("t2.pl_ready_body", 64'(pl_ready), 64'(1'b1));
    tick();
    expect_flit("t2.b0", 1'b0, 1'b0, 2'b10, 32'hA);
    pl_data = 32'hB;
    tick();
    expect_flit("t2.b1", 1'b0, 1'b0, 2'b10, 32'hB);
    pl_data = 32'hC;
    tick();
    expect_flit("t2.b2", 1'b0, 1'b1, 2'b10, 32'hC);
    check("t2.cnt", 64'(sent_pck_cnt), 64'(2));
    pl_valid = 1'b0;

    // credit1 is now 0: next request stalls in HDR
    request(8'd9, 5'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_no_flit("t3.stall");
    end
    credit_in = 2'b10;
    tick();
    expect_no_flit("t3.credit_cycle");
    // Credit returned again in the very cycle the header issues: count stays at 1
    pl_valid = 1'b1;
    pl_data  = 32'hD;
    tick();
    credit_in = 2'b00;
    expect_flit("t3.hdr", 1'b1, 1'b0, 2'b10, 32'h0002_0009);
    #1;
    check("t3.pl_ready_kept_credit", 64'(pl_ready), 64'(1'b1));
    tick();
    expect_flit("t3.tail", 1'b0, 1'b1, 2'b10, 32'hD);
    check("t3.cnt", 64'(sent_pck_cnt), 64'(3));
    pl_valid = 1'b0;

    // pl_valid toggling on vc0 (credit0 = 3)
    request(8'd3, 5'd3, 1'b0);
    tick();
    expect_flit("t4.hdr", 1'b1, 1'b0, 2'b01, 32'h0003_0003);
    pl_valid = 1'b1;
    pl_data  = 32'h11;
    #1;
    check("t4.pl_ready_v1", 64'(pl_ready), 64'(1'b1));
    tick();
    expect_flit("t4.b0", 1'b0, 1'b0, 2'b01, 32'h11);
    pl_valid = 1'b0;
    #1;
    check("t4.pl_ready_v0", 64'(pl_ready), 64'(1'b0));
    tick();
    expect_no_flit("t4.gap");
    pl_valid = 1'b1;
    pl_data  = 32'h22;
    tick();
    expect_flit("t4.tail", 1'b0, 1'b1, 2'b01, 32'h22);
    check("t4.cnt", 64'(sent_pck_cnt), 64'(4));
    check("t4.err_clear", 64'(credit_err), 64'(1'b0));
    pl_valid = 1'b0;

    // Refill both VCs to B, then overflow vc0
    credit_in = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    check("t5.err_at_B", 64'(credit_err), 64'(1'b0));
    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    check("t5.err_ovf", 64'(credit_err), 64'(1'b1));
    // Saturated at B: a len=5 packet sends exactly 4 flits then stalls
    pl_valid = 1'b1;
    pl_data  = 32'h77;
    request(8'd4, 5'd5, 1'b0);
    tick();
    expect_flit("t5.hdr", 1'b1, 1'b0, 2'b01, 32'h0005_0004);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_flit("t5.body", 1'b0, 1'b0, 2'b01, 32'h77);
    end
    tick();
    expect_no_flit("t5.stall");
    check("t5.pl_ready_stall", 64'(pl_ready), 64'(1'b0));
    credit_in = 2'b01;
    tick();
    credit_in = 2'b00;
    #1;
    check("t5.pl_ready_resume", 64'(pl_ready), 64'(1'b1));
    tick();
    expect_flit("t5.tail", 1'b0, 1'b1, 2'b01, 32'h77);
    check("t5.cnt", 64'(sent_pck_cnt), 64'(5));
    check("t5.err_sticky", 64'(credit_err), 64'(1'b1));
    tick();

    // Reset in the middle of a len=5 packet on vc1
    pl_data = 32'h55;
    request(8'd2, 5'd5, 1'b1);
    tick();
    expect_flit("t6.hdr", 1'b1, 1'b0, 2'b10, 32'h0005_0002);
    tick();
    expect_flit("t6.b0", 1'b0, 1'b0, 2'b10, 32'h55);
    reset = 1'b1;
    tick();
    check("t6.wr",        64'(flit_out_wr),   64'(1'b0));
    check("t6.tail",      64'(flit_out_tail), 64'(1'b0));
    check("t6.vc",        64'(flit_out_vc),   64'(2'b00));
    check("t6.data",      64'(flit_out_data), 64'(0));
    check("t6.err",       64'(credit_err),    64'(1'b0));
    check("t6.cnt",       64'(sent_pck_cnt),  64'(0));
    check("t6.req_ready", 64'(req_ready),     64'(1'b0));
    check("t6.pl_ready",  64'(pl_ready),      64'(1'b0));
    reset = 1'b0;
    #1;
    check("t6.req_ready_after", 64'(req_ready), 64'(1'b1));

    // len=20 clamps to 16 and flags an error; credits restored to B by reset
    pl_data = 32'h66;
    request(8'd1, 5'd20, 1'b0);
    check("t7.err_clamp", 64'(credit_err), 64'(1'b1));
    tick();
    expect_flit("t7.hdr", 1'b1, 1'b0, 2'b01, 32'h0010_0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_flit("t7.body", 1'b0, 1'b0, 2'b01, 32'h66);
    end
    tick();
    expect_no_flit("t7.stall");
    check("t7.cnt", 64'(sent_pck_cnt), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/endp_flit_injector.md
Name: endp_flit_injector

Overview:
- Endpoint-side packet-to-flit injector.
- Converts packet requests plus a payload stream into header/body/tail flits.
- Drives one router local input channel of the NoC top (one instance per endpoint, feeding that endpoint's chan_in slot).
- Credit-based flow control, one credit counter per virtual channel, fed by credit returns from the router local port.

Parameters:
- V, 2, number of virtual channels.
- B, 4, flit buffer depth per VC in the router input port; initial credit value.
- Fw, 32, flit payload width.
- EAw, 8, endpoint address width.
- MAX_PCK_SIZE, 16, maximum packet length in flits, header included.
- LENw, 5, width of the length field; equals clog2(MAX_PCK_SIZE+1).
- SRC_ADDR, 0, this endpoint's address, inserted in headers.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  1  packet request valid
- req_ready  output  1  request accepted when valid&ready
- req_dest  input  EAw  destination endpoint address
- req_len  input  LENw  packet length in flits (header included)
- req_vc  input  clog2(V)  VC index for the packet
- pl_valid  input  1  payload word valid
- pl_ready  output  1  payload word consumed when valid&ready
- pl_data  input  Fw  payload word
- flit_out_wr  output  1  flit valid toward router
- flit_out_hdr  output  1  header flag
- flit_out_tail  output  1  tail flag
- flit_out_vc  output  V  one-hot VC of flit
- flit_out_data  output  Fw  flit data
- credit_in  input  V  one-cycle credit return pulse per VC
- credit_err  output  1  sticky: credit overflow or illegal request
- sent_pck_cnt  output  32  number of tails sent, wraps

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE; all flit_out_* =0; credit_err=0; sent_pck_cnt=0; every credit counter =B.
  - req_ready=0 and pl_ready=0 during reset.
- Credit counters (per VC, width clog2(B+1)):
  - -1 on a flit issue decision for that VC; +1 on credit_in[v].
  - Both in the same cycle: value unchanged.
  - An increment that would exceed B saturates at B and sets credit_err.
  - Issue is allowed only when counter>0.
- FSM:
  - IDLE:
    - req_ready=1.
    - On accept, latch dest, vc and len; len==0 is clamped to 1; len>MAX_PCK_SIZE is clamped to MAX_PCK_SIZE and sets credit_err.
    - Next state HDR. No flit is issued in IDLE.
  - HDR:
    - When credit[vc]>0, issue the header.
    - Header data: [EAw-1:0]=dest, [2EAw-1:EAw]=SRC_ADDR, [2EAw+LENw-1:2EAw]=len, remaining bits 0.
    - hdr=1; tail=(len==1).
    - If len==1: sent_pck_cnt+1, go to IDLE. Otherwise remaining=len-1, go to BODY.
    - If credit is 0: stall in HDR, nothing issued.
  - BODY:
    - pl_ready = pl_valid & credit[vc]>0 (combinational from registered state and credit).
    - On transfer, issue a flit with data=pl_data, hdr=0, tail=(remaining==1); remaining decrements.
    - When tail is issued: sent_pck_cnt+1, go to IDLE.
    - Stall (no flit) on no payload or no credit.
- Latency and back-to-back:
  - Flit outputs are registered: flit_out_* reflect the issue decision one cycle later.
  - flit_out_wr is a one-cycle pulse per flit; flit_out_vc = one-hot(vc) when wr=1, else 0.
  - Back-to-back packets: after a tail the FSM returns to IDLE, so a new header issues no earlier than 2 cycles after the previous tail decision. Minimum packet time is len+1 cycles.
- VC behaviour:
  - Credits on other VCs are tracked continuously regardless of state.
  - A stalled packet never switches VC.
- Outside BODY, pl_ready=0. Payload is never consumed without a matching flit.
- Reset asserted mid-packet: abandon the packet, return to reset values next cycle. No tail is emitted; the NoC is reset together.
- sent_pck_cnt wraps 0xFFFFFFFF→0.

Test Plan:
- Reset, then request dest=5, len=1, vc=0 → after one IDLE cycle a single flit with hdr=1, tail=1, vc=01, data[7:0]=5, data[20:16]=1. sent_pck_cnt=1; credit0 = 3 until a credit is returned.
- Request len=4, vc=1, payload 0xA,0xB,0xC always valid, no credit returns → header plus 3 body flits on consecutive cycles, tail only on 0xC. credit1=0 afterwards; a following request stalls in HDR with no wr.
- With credit1=0 and a stalled header, pulse credit_in[1] once → header issues the next cycle, flit_out_wr appears one cycle later. Simultaneous credit_in and issue keeps the count constant.
- BODY with pl_valid toggling 1,0,1,0 → flits only on valid cycles, pl_ready never high while pl_valid=0, tail on the last word.
- Extra credit_in[0] pulse while credit0=B → counter stays 4, credit_err=1 and sticky until reset. req_len=20 → clamped to 16, credit_err set.
- Assert reset during BODY after 2 of 5 flits → next cycle all outputs 0, credits=B, req_ready returns to 1 after deassertion, no tail emitted.
